// File: rtl/demux2_pipe.sv
// Valid/ready 1:2 demultiplexer for 16-bit result words.
// Each destination has its own 2-entry FIFO and a wrapping delivered-word counter.
module demux2_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    // Index 0 is port A, index 1 is port B throughout.
    logic [WIDTH-1:0] mem [2][2];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       fill [2];
    logic [CNT_W-1:0] pop_cnt [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;

    // Ready looks only at the registered fill level, so a same-cycle pop never raises it.
    always_comb begin
        full[0]  = (fill[0] == 2'd2);
        full[1]  = (fill[1] == 2'd2);
        in_ready = in_sel ? !full[1] : !full[0];
        push[0]  = in_valid && in_ready && !in_sel;
        push[1]  = in_valid && in_ready && in_sel;
        pop[0]   = a_valid && a_ready;
        pop[1]   = b_valid && b_ready;
    end

    assign a_valid = (fill[0] != 2'd0);
    assign b_valid = (fill[1] != 2'd0);
    assign a_data  = mem[0][rd_ptr[0]];
    assign b_data  = mem[1][rd_ptr[1]];
    assign a_cnt   = pop_cnt[0];
    assign b_cnt   = pop_cnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned p = 0; p < 2; p++) begin
                fill[p]    <= '0;
                pop_cnt[p] <= '0;
                for (int unsigned e = 0; e < 2; e++) begin
                    mem[p][e] <= '0;
                end
            end
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (push[p]) begin
                    mem[p][wr_ptr[p]] <= in_data;
                    wr_ptr[p]         <= ~wr_ptr[p];
                end
                if (pop[p]) begin
                    rd_ptr[p]  <= ~rd_ptr[p];
                    pop_cnt[p] <= pop_cnt[p] + CNT_W'(1);
                end
                case ({push[p], pop[p]})
                    2'b10:   fill[p] <= fill[p] + 2'd1;
                    2'b01:   fill[p] <= fill[p] - 2'd1;
                    default: fill[p] <= fill[p];
                endcase
            end
        end
    end

endmodule
